// File: rtl/perf_counter_bank_if.sv
`default_nettype none
// ============================================================================
// Module : perf_counter_bank_if
// Control/readout bundle for the performance-counter bank.
// Rev    : 1.0
// ============================================================================
interface perf_counter_bank_if #(
  parameter int NUM_EVT = 2,
  parameter int WIDTH   = 32,
  parameter int SEL_W   = 2
);
  logic [NUM_EVT-1:0] evt;
  logic               syscall;
  logic [31:0]        r1;
  logic               resume;
  logic [NUM_EVT:0]   clr_ch;
  logic               snap;
  logic [SEL_W-1:0]   rd_sel;
  logic [WIDTH-1:0]   rd_data;
  logic [WIDTH-1:0]   cycle_count;
  logic               halted;
  logic [NUM_EVT:0]   ovf;

  modport master (
    output evt, syscall, r1, resume, clr_ch, snap, rd_sel,
    input  rd_data, cycle_count, halted, ovf
  );

  modport slave (
    input  evt, syscall, r1, resume, clr_ch, snap, rd_sel,
    output rd_data, cycle_count, halted, ovf
  );
endinterface
`default_nettype wire

// File: rtl/perf_counter_bank.sv
`default_nettype none
// ============================================================================
// Module : perf_counter_bank
// Cycle + NUM_EVT event counters with halt-on-syscall, snapshot shadows and a
// registered readout mux. Build option: PERF_CNT_SATURATE_EN (saturate, no wrap).
// Rev    : 1.0
// ============================================================================
module perf_counter_bank #(
  parameter int NUM_EVT    = 2,
  parameter int WIDTH      = 32,
  parameter int SEL_W      = 2,
  parameter int PRINT_CODE = 34
) (
  input  logic               clk,
  input  logic               clr,
  perf_counter_bank_if.slave bus
);
  localparam int NCH = NUM_EVT + 1;

  logic [WIDTH-1:0] cnt_q    [NCH];
  logic [WIDTH-1:0] cnt_d    [NCH];
  logic [WIDTH-1:0] shadow_q [NCH];
  logic [WIDTH-1:0] shadow_d [NCH];
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic [NCH-1:0]   ovf_q, ovf_d;
  logic             halted_q, halted_d;

  logic             w_stop;
  logic             w_run;
  logic [NCH-1:0]   w_inc;

  // The print service is the only syscall that keeps the counters running.
  assign w_stop = bus.syscall & (bus.r1 != 32'(PRINT_CODE));
  assign w_run  = ~halted_q & ~w_stop;
  assign w_inc  = {NCH{w_run}} & {bus.evt, 1'b1};

  always_comb begin
    halted_d = halted_q;
    if (w_stop)
      halted_d = 1'b1;
    else if (bus.resume)
      halted_d = 1'b0;
  end

  always_comb begin
    ovf_d = ovf_q;
    for (int k = 0; k < NCH; k++) begin
      cnt_d[k]    = cnt_q[k];
      shadow_d[k] = bus.snap ? cnt_q[k] : shadow_q[k];
      if (bus.clr_ch[k]) begin
        cnt_d[k] = '0;
        ovf_d[k] = 1'b0;
      end else if (w_inc[k]) begin
`ifdef PERF_CNT_SATURATE_EN
        if (&cnt_q[k])
          ovf_d[k] = 1'b1;
        else
          cnt_d[k] = cnt_q[k] + WIDTH'(1);
`else
        cnt_d[k] = cnt_q[k] + WIDTH'(1);
        if (&cnt_q[k])
          ovf_d[k] = 1'b1;
`endif
      end
    end
  end

  // Out-of-range selects fall through to zero.
  always_comb begin
    rd_data_d = '0;
    for (int k = 0; k < NCH; k++) begin
      if (bus.rd_sel == SEL_W'(k))
        rd_data_d = shadow_q[k];
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int k = 0; k < NCH; k++) begin
        cnt_q[k]    <= '0;
        shadow_q[k] <= '0;
      end
      rd_data_q <= '0;
      ovf_q     <= '0;
      halted_q  <= 1'b0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        cnt_q[k]    <= cnt_d[k];
        shadow_q[k] <= shadow_d[k];
      end
      rd_data_q <= rd_data_d;
      ovf_q     <= ovf_d;
      halted_q  <= halted_d;
    end
  end

  assign bus.rd_data     = rd_data_q;
  assign bus.cycle_count = cnt_q[0];
  assign bus.halted      = halted_q;
  assign bus.ovf         = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_perf_counter_bank.sv
`default_nettype none
// ============================================================================
// Module : tb_perf_counter_bank
// Directed self-checking bench for perf_counter_bank (NUM_EVT=2, WIDTH=8).
// Rev    : 1.0
// ============================================================================
module tb_perf_counter_bank;
  localparam int NUM_EVT = 2;
  localparam int WIDTH   = 8;
  localparam int SEL_W   = 2;
`ifdef PERF_CNT_SATURATE_EN
  localparam int SAT = 1;
`else
  localparam int SAT = 0;
`endif
  localparam logic [31:0] AFTER_WRAP = (SAT != 0) ? 32'd255 : 32'd0;
  localparam logic [31:0] CH1_PRE5   = (SAT != 0) ? 32'd255 : 32'd7;

  logic clk = 1'b0;
  logic clr;
  int   n_pass = 0;
  int   n_total = 0;

  perf_counter_bank_if #(.NUM_EVT(NUM_EVT), .WIDTH(WIDTH), .SEL_W(SEL_W)) bus ();

  perf_counter_bank #(
    .NUM_EVT(NUM_EVT), .WIDTH(WIDTH), .SEL_W(SEL_W), .PRINT_CODE(34)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  initial begin
    clr = 1'b1;
    bus.evt = '0; bus.syscall = 1'b0; bus.r1 = '0; bus.resume = 1'b0;
    bus.clr_ch = '0; bus.snap = 1'b0; bus.rd_sel = '0;
    step();
    clr = 1'b0;
    check("reset_cycle", 32'(bus.cycle_count), 32'd0);
    check("reset_halted", 32'(bus.halted), 32'd0);
    check("reset_ovf", 32'(bus.ovf), 32'd0);
    check("reset_rd", 32'(bus.rd_data), 32'd0);

    // idle counting
    step(10);
    check("idle_cycle", 32'(bus.cycle_count), 32'd10);
    check("idle_halted", 32'(bus.halted), 32'd0);

    // events, snapshot, readout
    bus.evt = 2'b11; step(3);
    bus.evt = 2'b01; step(2);
    bus.evt = 2'b00;
    bus.snap = 1'b1; step();
    bus.snap = 1'b0;
    bus.rd_sel = 2'd1; step(); check("rd_ch1", 32'(bus.rd_data), 32'd5);
    bus.rd_sel = 2'd2; step(); check("rd_ch2", 32'(bus.rd_data), 32'd3);
    bus.rd_sel = 2'd0; step(); check("rd_ch0", 32'(bus.rd_data), 32'd15);
    bus.rd_sel = 2'd3; step(); check("rd_oob", 32'(bus.rd_data), 32'd0);
    check("cycle_20", 32'(bus.cycle_count), 32'd20);

    // syscalls and halt
    bus.syscall = 1'b1; bus.r1 = 32'd34; step();
    check("print_counted", 32'(bus.cycle_count), 32'd21);
    check("print_no_halt", 32'(bus.halted), 32'd0);
    bus.r1 = 32'd10; step();
    check("stop_not_counted", 32'(bus.cycle_count), 32'd21);
    check("stop_halted", 32'(bus.halted), 32'd1);
    bus.syscall = 1'b0; bus.evt = 2'b11; step(20);
    check("frozen_cycle", 32'(bus.cycle_count), 32'd21);
    check("frozen_halted", 32'(bus.halted), 32'd1);
    bus.resume = 1'b1; step();
    check("resume_clears", 32'(bus.halted), 32'd0);
    check("resume_cycle_idle", 32'(bus.cycle_count), 32'd21);
    bus.resume = 1'b0; step();
    bus.evt = 2'b00;
    check("resume_counts", 32'(bus.cycle_count), 32'd22);
    bus.syscall = 1'b1; bus.r1 = 32'd10; step();
    bus.resume = 1'b1; step();
    check("stop_beats_resume", 32'(bus.halted), 32'd1);
    check("stop_beats_resume_cnt", 32'(bus.cycle_count), 32'd22);
    bus.syscall = 1'b0; step();
    bus.resume = 1'b0; step();
    check("resume2_cycle", 32'(bus.cycle_count), 32'd23);
    bus.snap = 1'b1; step();
    bus.snap = 1'b0;
    bus.rd_sel = 2'd1; step(); check("post_halt_ch1", 32'(bus.rd_data), 32'd6);
    bus.rd_sel = 2'd2; step(); check("post_halt_ch2", 32'(bus.rd_data), 32'd4);

    // wrap / saturate of channel 1
    bus.clr_ch = 3'b011; step();
    bus.clr_ch = 3'b000;
    bus.evt = 2'b01; step(255);
    bus.evt = 2'b00;
    bus.snap = 1'b1; step();
    bus.snap = 1'b0;
    check("pre_wrap_ovf1", 32'(bus.ovf[1]), 32'd0);
    bus.rd_sel = 2'd1; step(); check("ch1_255", 32'(bus.rd_data), 32'd255);
    bus.evt = 2'b01; step();
    bus.evt = 2'b00;
    check("wrap_ovf1", 32'(bus.ovf[1]), 32'd1);
    bus.snap = 1'b1; step();
    bus.snap = 1'b0; step();
    check("wrap_value", 32'(bus.rd_data), AFTER_WRAP);
    bus.clr_ch = 3'b001; step();
    bus.clr_ch = 3'b000;
    check("clr_ch0_cycle", 32'(bus.cycle_count), 32'd0);
    check("clr_ch0_ovf", 32'(bus.ovf), 32'b010);

    // clear beats event, snap sees pre-clear value
    bus.evt = 2'b01; step(7);
    bus.clr_ch = 3'b010; bus.snap = 1'b1; step();
    bus.clr_ch = 3'b000; bus.snap = 1'b0; bus.evt = 2'b00;
    check("clr_ch1_ovf", 32'(bus.ovf), 32'd0);
    bus.rd_sel = 2'd1; step(); check("shadow_pre_clear", 32'(bus.rd_data), CH1_PRE5);
    bus.rd_sel = 2'd0; step(); check("shadow_ch0", 32'(bus.rd_data), 32'd7);
    check("cycle_after_clr_ch", 32'(bus.cycle_count), 32'd10);
    bus.evt = 2'b01; step(2);
    bus.evt = 2'b00;
    bus.rd_sel = 2'd1; bus.snap = 1'b1; step();
    check("snap_read_same", 32'(bus.rd_data), CH1_PRE5);
    bus.snap = 1'b0; step();
    check("snap_read_next", 32'(bus.rd_data), 32'd2);

    // global clear while halted with overflow pending
    step(250);
    bus.syscall = 1'b1; bus.r1 = 32'd0; step();
    bus.syscall = 1'b0;
    check("pre_clr_halted", 32'(bus.halted), 32'd1);
    check("pre_clr_ovf0", 32'(bus.ovf[0]), 32'd1);
    clr = 1'b1; step();
    clr = 1'b0;
    check("clr_cycle", 32'(bus.cycle_count), 32'd0);
    check("clr_halted", 32'(bus.halted), 32'd0);
    check("clr_ovf", 32'(bus.ovf), 32'd0);
    check("clr_rd", 32'(bus.rd_data), 32'd0);
    step(); check("clr_shadow1", 32'(bus.rd_data), 32'd0);
    bus.rd_sel = 2'd2; step(); check("clr_shadow2", 32'(bus.rd_data), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
